reg_file_bank: RTL

- Parametrised successor register file for the multi-cycle MIPS datapath: two asynchronous read ports and one synchronous write port.
- Configurable width and depth, per-byte write enables, and optional hardwired-zero entry 0.
- Entries are cleared by a sequential clear engine, one entry per cycle, instead of a parallel reset. This keeps the array inferable as distributed RAM.
- Sits between the control FSM/ALU writeback mux and the A/B operand registers.

---
 rtl/reg_file_bank.sv | 120 ++++++++++++
 1 files changed

// File: rtl/reg_file_bank.sv
// reg_file_bank: register file with two combinational read ports and one synchronous,
// byte-enabled write port. After reset, a clear engine zeroes one entry per cycle.
// There is no parallel reset of the array, so it can still be inferred as distributed RAM.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset; restarts the clear engine at entry 0
//   r1_addr/r2_addr  read addresses
//   r1_dout/r2_dout  read data; 0 while busy, for entry 0 (ZERO_R0=1) or addr >= DEPTH
//   r3_addr/r3_din   write address / data
//   r3_wr            write strobe; dropped (not queued) while busy
//   r3_be            byte enables, bit b covers r3_din[8b+7:8b]
//   busy             clear engine active
//
// Optional feature: define REGFILE_BYPASS_EN to forward a legal same-cycle write to any
// read port that addresses the written entry. The forwarding is applied per byte.
module reg_file_bank #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DEPTH   = 32,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [ADDR_W-1:0]   r2_addr,
  input  logic [ADDR_W-1:0]   r3_addr,
  input  logic [DATA_W-1:0]   r3_din,
  input  logic                r3_wr,
  input  logic [DATA_W/8-1:0] r3_be,
  output logic [DATA_W-1:0]   r1_dout,
  output logic [DATA_W-1:0]   r2_dout,
  output logic                busy
);

  localparam int unsigned NumBytes = DATA_W / 8;
  // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr, w_clr_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_busy;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_raddr [2];
  logic [DATA_W-1:0]   w_rdata [2];

  // Clear engine state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StClear;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    unique case (r_state)
      StClear: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == LastIdx) begin
          w_state_nxt   = StIdle;
          w_clr_ptr_nxt = '0;
        end
      end
      StIdle: ;
    endcase
  end

  assign w_busy = (r_state == StClear);
  assign busy   = w_busy;

  assign w_wr_en = !w_busy && r3_wr && ({1'b0, r3_addr} < DepthW) &&
                   !(ZERO_R0 && (r3_addr == '0));

  // Array has no reset; the clear engine owns the write port while busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_busy) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_en) begin
        for (int unsigned b = 0; b < NumBytes; b++) begin
          if (r3_be[b]) r_mem[r3_addr][8*b +: 8] <= r3_din[8*b +: 8];
        end
      end
    end
  end

  assign w_raddr[0] = r1_addr;
  assign w_raddr[1] = r2_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = '0;
      if (!w_busy && ({1'b0, w_raddr[p]} < DepthW) && !(ZERO_R0 && (w_raddr[p] == '0))) begin
        w_rdata[p] = r_mem[w_raddr[p]];
`ifdef REGFILE_BYPASS_EN
        // w_wr_en already implies a legal target, so an address match is enough.
        if (w_wr_en && (w_raddr[p] == r3_addr)) begin
          for (int unsigned b = 0; b < NumBytes; b++) begin
            if (r3_be[b]) w_rdata[p][8*b +: 8] = r3_din[8*b +: 8];
          end
        end
`endif
      end
    end
  end

  assign r1_dout = w_rdata[0];
  assign r2_dout = w_rdata[1];

endmodule
